// File: rtl/i2s_tx_sequencer.sv
// I2S transmit sequencer: buffers one stereo frame and serializes it MSB-first on timing-generator strobes.
// Optional macro AUDIO_UNDERRUN_HOLD_EN: an underrun repeats the previous frame instead of sending silence.
module i2s_tx_sequencer #(
    parameter int BITS_PER_SAMPLE = 16,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       lrclk,
    input  logic                       load_strobe,
    input  logic                       shift_strobe,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [BITS_PER_SAMPLE-1:0] s_left,
    input  logic [BITS_PER_SAMPLE-1:0] s_right,
    output logic                       i2s_sdata,
    output logic                       underrun,
    output logic [CNT_WIDTH-1:0]       underrun_count
);

    localparam int BC_W = (BITS_PER_SAMPLE > 1) ? $clog2(BITS_PER_SAMPLE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t state, state_next;

    logic                       hold_full;
    logic [BITS_PER_SAMPLE-1:0] hold_left, hold_right;
    logic [BITS_PER_SAMPLE-1:0] frame_left, frame_right;
    logic [BITS_PER_SAMPLE-1:0] shreg;
    logic [BC_W-1:0]            bitcnt;

    logic                       left_load, right_load, is_underrun, xfer;
    logic [BITS_PER_SAMPLE-1:0] next_left, next_right, load_word;

    // s_ready depends only on registered state, never on s_valid
    assign s_ready = (state != IDLE) && !hold_full;
    assign xfer    = s_valid && s_ready;

    always_comb begin
        state_next  = state;
        left_load   = 1'b0;
        right_load  = 1'b0;
        case (state)
            IDLE: state_next = SYNC;
            SYNC: begin
                if (load_strobe && !lrclk) begin
                    left_load  = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                left_load  = load_strobe && !lrclk;
                right_load = load_strobe && lrclk;
            end
            default: state_next = IDLE;
        endcase
        if (!enable) begin
            state_next = IDLE;
            left_load  = 1'b0;
            right_load = 1'b0;
        end

        is_underrun = left_load && !hold_full;
        if (hold_full) begin
            next_left  = hold_left;
            next_right = hold_right;
        end else begin
`ifdef AUDIO_UNDERRUN_HOLD_EN
            next_left  = frame_left;
            next_right = frame_right;
`else
            next_left  = '0;
            next_right = '0;
`endif
        end
        load_word = right_load ? frame_right : next_left;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_full      <= 1'b0;
            hold_left      <= '0;
            hold_right     <= '0;
            frame_left     <= '0;
            frame_right    <= '0;
            shreg          <= '0;
            bitcnt         <= '0;
            i2s_sdata      <= 1'b0;
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else if (!enable) begin
            hold_full   <= 1'b0;
            hold_left   <= '0;
            hold_right  <= '0;
            frame_left  <= '0;
            frame_right <= '0;
            shreg       <= '0;
            bitcnt      <= '0;
            i2s_sdata   <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            underrun <= is_underrun;
            if (is_underrun && (underrun_count != '1))
                underrun_count <= underrun_count + CNT_WIDTH'(1);

            if (left_load) begin
                frame_left  <= next_left;
                frame_right <= next_right;
            end

            // a same-cycle transfer only happens with hold empty, so it never races a pop
            if (xfer) begin
                hold_left  <= s_left;
                hold_right <= s_right;
                hold_full  <= 1'b1;
            end else if (left_load) begin
                hold_full <= 1'b0;
            end

            if (left_load || right_load) begin
                i2s_sdata <= load_word[BITS_PER_SAMPLE-1];
                shreg     <= {load_word[BITS_PER_SAMPLE-2:0], 1'b0};
                bitcnt    <= BC_W'(BITS_PER_SAMPLE - 1);
            end else if (shift_strobe) begin
                if (bitcnt != '0) begin
                    i2s_sdata <= shreg[BITS_PER_SAMPLE-1];
                    shreg     <= {shreg[BITS_PER_SAMPLE-2:0], 1'b0};
                    bitcnt    <= bitcnt - BC_W'(1);
                end else begin
                    i2s_sdata <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Self-checking bench for i2s_tx_sequencer: directed steps plus random strobes against a queue-based model.
// Build with +define+AUDIO_UNDERRUN_HOLD_EN to check the frame-repeat variant.
module tb_i2s_tx_sequencer;

    localparam int BITS    = 16;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            enable = 1'b0, lrclk = 1'b0, load_strobe = 1'b0, shift_strobe = 1'b0, s_valid = 1'b0;
    logic [BITS-1:0] s_left = '0, s_right = '0;
    logic            s_ready, i2s_sdata, underrun;
    logic [CW-1:0]   underrun_count;

    i2s_tx_sequencer #(.BITS_PER_SAMPLE(BITS), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .lrclk          (lrclk),
        .load_strobe    (load_strobe),
        .shift_strobe   (shift_strobe),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_left         (s_left),
        .s_right        (s_right),
        .i2s_sdata      (i2s_sdata),
        .underrun       (underrun),
        .underrun_count (underrun_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: mode 0 = muted, 1 = waiting for first left load, 2 = streaming
    int                m_mode = 0;
    logic [2*BITS-1:0] m_hold[$];
    logic [BITS-1:0]   m_frame_l = '0, m_frame_r = '0;
    bit                m_bits[$];
    logic              m_sdata = 1'b0, m_under = 1'b0;
    int                m_count = 0;

    task automatic modelReset();
        m_mode = 0;
        m_hold.delete();
        m_frame_l = '0;
        m_frame_r = '0;
        m_bits.delete();
        m_sdata = 1'b0;
        m_under = 1'b0;
        m_count = 0;
    endtask

    task automatic modelLoad(input logic [BITS-1:0] w);
        m_bits.delete();
        for (int i = BITS - 1; i >= 0; i--) m_bits.push_back(w[i]);
        m_sdata = m_bits.pop_front();
    endtask

    task automatic modelStep(input logic en, lr, ld, sh, sv, input logic [BITS-1:0] sl, sr);
        bit xfer;
        xfer    = sv && (m_mode != 0) && (m_hold.size() == 0);
        m_under = 1'b0;
        if (!en) begin
            m_mode = 0;
            m_hold.delete();
            m_frame_l = '0;
            m_frame_r = '0;
            m_bits.delete();
            m_sdata = 1'b0;
            return;
        end
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (ld && !lr) begin
            if (m_hold.size() != 0) begin
                {m_frame_l, m_frame_r} = m_hold.pop_front();
            end else begin
                m_under = 1'b1;
                if (m_count < CNT_MAX) m_count++;
`ifndef AUDIO_UNDERRUN_HOLD_EN
                m_frame_l = '0;
                m_frame_r = '0;
`endif
            end
            m_mode = 2;
            modelLoad(m_frame_l);
        end else if (ld && lr && m_mode == 2) begin
            modelLoad(m_frame_r);
        end else if (sh && !ld) begin
            m_sdata = (m_bits.size() != 0) ? m_bits.pop_front() : 1'b0;
        end
        if (xfer) m_hold.push_back({sl, sr});
    endtask

    task automatic checkOutput(input string tag);
        logic exp_ready;
        exp_ready = (m_mode != 0) && (m_hold.size() == 0);
        total++;
        assert (i2s_sdata === m_sdata) else begin
            bad++;
            $error("[TB] FAIL %s sdata: got %b want %b", tag, i2s_sdata, m_sdata);
        end
        total++;
        assert (s_ready === exp_ready) else begin
            bad++;
            $error("[TB] FAIL %s s_ready: got %b want %b", tag, s_ready, exp_ready);
        end
        total++;
        assert (underrun === m_under) else begin
            bad++;
            $error("[TB] FAIL %s underrun: got %b want %b", tag, underrun, m_under);
        end
        total++;
        assert (underrun_count === CW'(m_count)) else begin
            bad++;
            $error("[TB] FAIL %s underrun_count: got %0d want %0d", tag, underrun_count, m_count);
        end
    endtask

    task automatic applyStimulus(input logic en, lr, ld, sh, sv,
                                 input logic [BITS-1:0] sl, sr, input string tag);
        enable       = en;
        lrclk        = lr;
        load_strobe  = ld;
        shift_strobe = sh;
        s_valid      = sv;
        s_left       = sl;
        s_right      = sr;
        @(posedge clk);
        #1;
        modelStep(en, lr, ld, sh, sv, sl, sr);
        checkOutput(tag);
    endtask

    initial begin
        logic [BITS-1:0] word;
        logic [BITS-1:0] rl, rr;

        #2 reset = 1'b1;
        #10;
        modelReset();
        checkOutput("reset");
        @(negedge clk) reset = 1'b0;

        applyStimulus(1, 0, 0, 0, 0, '0, '0, "enable");
        applyStimulus(1, 0, 0, 0, 1, 16'hA5F0, 16'h0F0F, "push_a5f0");
        applyStimulus(1, 0, 0, 0, 0, '0, '0, "held");

        // left word A5F0, then padding shifts
        applyStimulus(1, 0, 1, 0, 0, '0, '0, "left_load");
        word = {word[BITS-2:0], i2s_sdata};
        for (int i = 1; i < BITS; i++) begin
            applyStimulus(1, 0, 0, 1, 0, '0, '0, "left_shift");
            word = {word[BITS-2:0], i2s_sdata};
        end
        total++;
        assert (word === 16'hA5F0) else begin
            bad++;
            $error("[TB] FAIL left_word: got %h want %h", word, 16'hA5F0);
        end
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 1, 0, '0, '0, "left_pad");

        applyStimulus(1, 1, 1, 0, 0, '0, '0, "right_load");
        word = {word[BITS-2:0], i2s_sdata};
        for (int i = 1; i < BITS; i++) begin
            applyStimulus(1, 1, 0, 1, 0, '0, '0, "right_shift");
            word = {word[BITS-2:0], i2s_sdata};
        end
        total++;
        assert (word === 16'h0F0F) else begin
            bad++;
            $error("[TB] FAIL right_word: got %h want %h", word, 16'h0F0F);
        end
        applyStimulus(1, 1, 0, 1, 0, '0, '0, "right_pad");

        // load and shift in the same cycle: the load wins
        rl = BITS'($urandom);
        rr = BITS'($urandom);
        applyStimulus(1, 1, 0, 0, 1, rl, rr, "push_rand");
        applyStimulus(1, 0, 1, 1, 0, '0, '0, "load_and_shift");
        for (int i = 0; i < BITS + 1; i++) applyStimulus(1, 0, 0, 1, 0, '0, '0, "ls_shift");

        // prior frame 8001, then three underruns
        applyStimulus(1, 1, 0, 0, 1, 16'h8001, 16'h8001, "push_8001");
        applyStimulus(1, 0, 1, 0, 0, '0, '0, "left_8001");
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 1, 0, '0, '0, "shift_8001");
        for (int u = 0; u < 3; u++) begin
            applyStimulus(1, 0, 1, 0, 0, '0, '0, "underrun_left");
            for (int i = 1; i < BITS; i++) applyStimulus(1, 0, 0, 1, 0, '0, '0, "underrun_shift");
            applyStimulus(1, 1, 1, 0, 0, '0, '0, "underrun_right");
            for (int i = 1; i < BITS; i++) applyStimulus(1, 1, 0, 1, 0, '0, '0, "underrun_rshift");
        end
        total++;
        assert (underrun_count === CW'(3)) else begin
            bad++;
            $error("[TB] FAIL underrun_three: got %0d want 3", underrun_count);
        end

        // s_valid held high with fresh data every cycle: one frame per left load
        for (int f = 0; f < 4; f++) begin
            applyStimulus(1, 0, 1, 0, 1, BITS'($urandom), BITS'($urandom), "stream_left");
            for (int i = 1; i < BITS; i++)
                applyStimulus(1, 0, 0, 1, 1, BITS'($urandom), BITS'($urandom), "stream_lshift");
            applyStimulus(1, 1, 1, 0, 1, BITS'($urandom), BITS'($urandom), "stream_right");
            for (int i = 1; i < BITS; i++)
                applyStimulus(1, 1, 0, 1, 1, BITS'($urandom), BITS'($urandom), "stream_rshift");
        end

        // mute mid-word, then a right-half load while resyncing is ignored
        applyStimulus(1, 0, 1, 0, 0, '0, '0, "pre_mute_left");
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 1, 0, '0, '0, "pre_mute_shift");
        applyStimulus(0, 0, 0, 1, 1, 16'hFFFF, 16'hFFFF, "mute");
        applyStimulus(1, 1, 0, 0, 0, '0, '0, "unmute");
        applyStimulus(1, 1, 1, 0, 0, '0, '0, "sync_right_ignored");
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 1, 0, '0, '0, "sync_shift");
        applyStimulus(1, 1, 0, 0, 1, 16'hFFFF, 16'h1234, "resync_push");
        applyStimulus(1, 0, 1, 0, 0, '0, '0, "resync_left");

        // counter saturation
        for (int u = 0; u < CNT_MAX + 4; u++) begin
            applyStimulus(1, 0, 1, 0, 0, '0, '0, "sat_left");
            applyStimulus(1, 0, 0, 1, 0, '0, '0, "sat_shift");
        end
        total++;
        assert (underrun_count === CW'(CNT_MAX)) else begin
            bad++;
            $error("[TB] FAIL saturate: got %0d want %0d", underrun_count, CNT_MAX);
        end

        // asynchronous reset mid-frame
        applyStimulus(1, 0, 0, 0, 1, 16'hC3C3, 16'h3C3C, "pre_reset_push");
        applyStimulus(1, 0, 1, 0, 0, '0, '0, "pre_reset_left");
        applyStimulus(1, 0, 0, 1, 0, '0, '0, "pre_reset_shift");
        #2 reset = 1'b1;
        #1;
        modelReset();
        checkOutput("async_reset");
        @(negedge clk) reset = 1'b0;

        for (int c = 0; c < 2000; c++) begin
            applyStimulus(($urandom_range(0, 59) != 0), 1'($urandom), ($urandom_range(0, 7) == 0),
                          1'($urandom), ($urandom_range(0, 3) == 0),
                          BITS'($urandom), BITS'($urandom), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
